// File: rtl/lsu_lane_array.sv
// Purpose    : multi-lane load/store unit; serialises one memory transaction per active lane onto a single memory port.
// Latency    : REQUEST capture to DONE = 1 + K*(2 + ack_wait) cycles for K active lanes; 2 cycles for an empty mask.
// Backpressure: valid/address/data are held until the matching ack is sampled; enable low freezes everything.
//
// Ports:
//   clk, rst_n                        clock, asynchronous active-low reset
//   enable                            low = hold all state and outputs, ignore acks
//   simd_state                        scheduler state (3'b011 REQUEST starts an op, 3'b110 UPDATE releases DONE)
//   mem_read, mem_write               op select at REQUEST (read wins if both set)
//   lane_mask, lane_addr, lane_wdata  per-lane participation, address and store data (lane i at [i*W +: W])
//   mem_read_ack/_data, mem_write_ack memory completion handshake
//   mem_read_valid/_addr              read request to memory
//   mem_write_valid/_addr/_data       write request to memory
//   lsu_state                         00 IDLE, 01 REQUESTING, 10 WAITING, 11 DONE
//   lane_done, lane_read_data         per-lane completion flags and load results
module lsu_lane_array #(
    parameter int NUM_LANES  = 4,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             enable,
    input  logic [2:0]                       simd_state,
    input  logic                             mem_read,
    input  logic                             mem_write,
    input  logic [NUM_LANES-1:0]             lane_mask,
    input  logic [NUM_LANES*ADDR_WIDTH-1:0]  lane_addr,
    input  logic [NUM_LANES*DATA_WIDTH-1:0]  lane_wdata,
    input  logic                             mem_read_ack,
    input  logic [DATA_WIDTH-1:0]            mem_read_data,
    input  logic                             mem_write_ack,
    output logic                             mem_read_valid,
    output logic [ADDR_WIDTH-1:0]            mem_read_addr,
    output logic                             mem_write_valid,
    output logic [ADDR_WIDTH-1:0]            mem_write_addr,
    output logic [DATA_WIDTH-1:0]            mem_write_data,
    output logic [1:0]                       lsu_state,
    output logic [NUM_LANES-1:0]             lane_done,
    output logic [NUM_LANES*DATA_WIDTH-1:0]  lane_read_data
);

    localparam int SEL_W = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;

    localparam logic [2:0] SIMD_REQUEST = 3'b011;
    localparam logic [2:0] SIMD_UPDATE  = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    state_t                          state_q, state_d;
    logic                            op_read_q, op_read_d;
    logic [NUM_LANES-1:0]            pending_q, pending_d;
    logic [NUM_LANES*ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [NUM_LANES*DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [SEL_W-1:0]                sel_q, sel_d;
    logic                            rd_vld_q, rd_vld_d;
    logic                            wr_vld_q, wr_vld_d;
    logic [ADDR_WIDTH-1:0]           rd_addr_q, rd_addr_d;
    logic [ADDR_WIDTH-1:0]           wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]           wr_data_q, wr_data_d;
    logic [NUM_LANES-1:0]            lane_done_q, lane_done_d;
    logic [NUM_LANES*DATA_WIDTH-1:0] lane_rdata_q, lane_rdata_d;

    // Lowest pending lane and its captured address/data
    logic                            found;
    logic [SEL_W-1:0]                sel_lo;
    logic [ADDR_WIDTH-1:0]           sel_addr;
    logic [DATA_WIDTH-1:0]           sel_wdata;
    logic                            op_ack;

    always_comb begin
        found  = 1'b0;
        sel_lo = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (!found && pending_q[i]) begin
                found  = 1'b1;
                sel_lo = SEL_W'(i);
            end
        end
        sel_addr  = '0;
        sel_wdata = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (SEL_W'(i) == sel_lo) begin
                sel_addr  = addr_q[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = wdata_q[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Only the ack belonging to the op in flight can complete a transaction
    assign op_ack = op_read_q ? mem_read_ack : mem_write_ack;

    always_comb begin
        state_d      = state_q;
        op_read_d    = op_read_q;
        pending_d    = pending_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        sel_d        = sel_q;
        rd_vld_d     = rd_vld_q;
        wr_vld_d     = wr_vld_q;
        rd_addr_d    = rd_addr_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        lane_done_d  = lane_done_q;
        lane_rdata_d = lane_rdata_q;

        if (enable) begin
            case (state_q)
                ST_IDLE: begin
                    if (simd_state == SIMD_REQUEST && (mem_read || mem_write)) begin
                        op_read_d   = mem_read;
                        pending_d   = lane_mask;
                        addr_d      = lane_addr;
                        wdata_d     = lane_wdata;
                        lane_done_d = '0;
                        state_d     = ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (pending_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        sel_d = sel_lo;
                        if (op_read_q) begin
                            rd_vld_d  = 1'b1;
                            rd_addr_d = sel_addr;
                        end else begin
                            wr_vld_d  = 1'b1;
                            wr_addr_d = sel_addr;
                            wr_data_d = sel_wdata;
                        end
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (op_ack) begin
                        rd_vld_d = 1'b0;
                        wr_vld_d = 1'b0;
                        for (int i = 0; i < NUM_LANES; i++) begin
                            if (SEL_W'(i) == sel_q) begin
                                lane_done_d[i] = 1'b1;
                                pending_d[i]   = 1'b0;
                                if (op_read_q) begin
                                    lane_rdata_d[i*DATA_WIDTH +: DATA_WIDTH] = mem_read_data;
                                end
                            end
                        end
                        state_d = (pending_d == '0) ? ST_DONE : ST_REQ;
                    end
                end
                ST_DONE: begin
                    if (simd_state == SIMD_UPDATE) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            op_read_q    <= 1'b0;
            pending_q    <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            sel_q        <= '0;
            rd_vld_q     <= 1'b0;
            wr_vld_q     <= 1'b0;
            rd_addr_q    <= '0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            lane_done_q  <= '0;
            lane_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            op_read_q    <= op_read_d;
            pending_q    <= pending_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            sel_q        <= sel_d;
            rd_vld_q     <= rd_vld_d;
            wr_vld_q     <= wr_vld_d;
            rd_addr_q    <= rd_addr_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            lane_done_q  <= lane_done_d;
            lane_rdata_q <= lane_rdata_d;
        end
    end

    assign mem_read_valid  = rd_vld_q;
    assign mem_read_addr   = rd_addr_q;
    assign mem_write_valid = wr_vld_q;
    assign mem_write_addr  = wr_addr_q;
    assign mem_write_data  = wr_data_q;
    assign lsu_state       = state_q;
    assign lane_done       = lane_done_q;
    assign lane_read_data  = lane_rdata_q;

endmodule

// File: tb/tb_lsu_lane_array.sv
// Purpose    : directed bench for lsu_lane_array with a scoreboard of expected memory transactions.
// Latency    : checks REQUEST-to-DONE cycle counts against 1 + K*(2 + ack delay), 2 for an empty mask.
// Backpressure: a memory responder delays acks by a programmable number of cycles.
module tb_lsu_lane_array;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         enable;
    logic [2:0]   simd_state;
    logic         mem_read;
    logic         mem_write;
    logic [3:0]   lane_mask;
    logic [31:0]  lane_addr;
    logic [255:0] lane_wdata;
    logic         mem_read_ack;
    logic [63:0]  mem_read_data;
    logic         mem_write_ack;
    logic         mem_read_valid;
    logic [7:0]   mem_read_addr;
    logic         mem_write_valid;
    logic [7:0]   mem_write_addr;
    logic [63:0]  mem_write_data;
    logic [1:0]   lsu_state;
    logic [3:0]   lane_done;
    logic [255:0] lane_read_data;

    lsu_lane_array dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable          (enable),
        .simd_state      (simd_state),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .lane_mask       (lane_mask),
        .lane_addr       (lane_addr),
        .lane_wdata      (lane_wdata),
        .mem_read_ack    (mem_read_ack),
        .mem_read_data   (mem_read_data),
        .mem_write_ack   (mem_write_ack),
        .mem_read_valid  (mem_read_valid),
        .mem_read_addr   (mem_read_addr),
        .mem_write_valid (mem_write_valid),
        .mem_write_addr  (mem_write_addr),
        .mem_write_data  (mem_write_data),
        .lsu_state       (lsu_state),
        .lane_done       (lane_done),
        .lane_read_data  (lane_read_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_read;
        logic [7:0]  addr;
        logic [63:0] data;
    } txn_t;

    txn_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   n_txn  = 0;
    int   n_rd   = 0;
    int   n_wr   = 0;

    // Memory responder (auto) and manual override
    bit          man_mode  = 1'b0;
    logic        man_rack  = 1'b0;
    logic [63:0] man_rdata = '0;
    logic        auto_rack = 1'b0;
    logic        auto_wack = 1'b0;
    logic [63:0] auto_rdata = '0;
    int          ack_delay = 0;
    int          wcnt = 0;
    logic [7:0]  cur_addr;
    logic [63:0] cur_data;

    assign mem_read_ack  = man_mode ? man_rack  : auto_rack;
    assign mem_read_data = man_mode ? man_rdata : auto_rdata;
    assign mem_write_ack = man_mode ? 1'b0      : auto_wack;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #1;
        if (!rst_n || man_mode) begin
            auto_rack = 1'b0;
            auto_wack = 1'b0;
            wcnt      = 0;
        end else if (mem_read_valid || mem_write_valid) begin
            check("one_valid", {255'd0, mem_read_valid && mem_write_valid}, 256'd0);
            if (mem_read_valid) n_rd++;
            if (mem_write_valid) n_wr++;
            if (wcnt == 0) begin
                txn_t e;
                n_txn++;
                cur_addr = mem_read_valid ? mem_read_addr : mem_write_addr;
                cur_data = mem_write_data;
                if (sb.size() == 0) begin
                    check("unexpected_txn", 256'd1, 256'd0);
                end else begin
                    e = sb.pop_front();
                    check("txn_is_read", {255'd0, mem_read_valid}, {255'd0, e.is_read});
                    check("txn_addr", {248'd0, cur_addr}, {248'd0, e.addr});
                    if (!e.is_read) check("txn_wdata", {192'd0, mem_write_data}, {192'd0, e.data});
                end
            end else begin
                check("addr_stable", {248'd0, (mem_read_valid ? mem_read_addr : mem_write_addr)},
                      {248'd0, cur_addr});
                if (mem_write_valid) check("wdata_stable", {192'd0, mem_write_data}, {192'd0, cur_data});
            end
            auto_rack  = mem_read_valid  && (wcnt >= ack_delay);
            auto_wack  = mem_write_valid && (wcnt >= ack_delay);
            auto_rdata = {52'd0, mem_read_addr, 4'd0};
            wcnt++;
        end else begin
            auto_rack = 1'b0;
            auto_wack = 1'b0;
            wcnt      = 0;
        end
    end

    // Issues one op, scoreboards its transactions, checks latency, then releases with UPDATE.
    task automatic run_op(input string tag, input bit r, input bit w, input logic [3:0] mask,
                          input logic [31:0] addrv, input logic [255:0] wdv, input int delay,
                          input bit scramble);
        int k;
        int exp_edges;
        int edges;
        ack_delay  = delay;
        simd_state = 3'b011;
        mem_read   = r;
        mem_write  = w;
        lane_mask  = mask;
        lane_addr  = addrv;
        lane_wdata = wdv;
        k = 0;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) begin
                txn_t t;
                t.is_read = r;
                t.addr    = addrv[i*8 +: 8];
                t.data    = r ? 64'd0 : wdv[i*64 +: 64];
                sb.push_back(t);
                k++;
            end
        end
        exp_edges = (k == 0) ? 2 : 1 + k * (2 + delay);
        tick();
        edges = 1;
        simd_state = 3'b000;
        if (scramble) begin
            mem_read   = 1'b0;
            mem_write  = 1'b1;
            lane_mask  = 4'b0000;
            lane_addr  = 32'hFFFF_FFFF;
            lane_wdata = {4{64'hDEAD_BEEF_DEAD_BEEF}};
        end
        while (lsu_state != 2'b11 && edges < 200) begin
            tick();
            edges++;
        end
        check({tag, "_latency"}, edges, exp_edges);
        check({tag, "_sb_empty"}, sb.size(), 0);
        sb.delete();
        simd_state = 3'b110;
        tick();
        check({tag, "_update_idle"}, {254'd0, lsu_state}, 256'd0);
        simd_state = 3'b000;
    endtask

    initial begin
        rst_n      = 1'b0;
        enable     = 1'b1;
        simd_state = 3'b000;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        lane_mask  = '0;
        lane_addr  = '0;
        lane_wdata = '0;
        #12;
        check("rst_state", {254'd0, lsu_state}, 256'd0);
        check("rst_valids", {254'd0, mem_read_valid, mem_write_valid}, 256'd0);
        check("rst_lane_data", lane_read_data, 256'd0);
        rst_n = 1'b1;
        tick();

        // 1: four-lane load with immediate ack
        n_txn = 0; n_rd = 0; n_wr = 0;
        run_op("t1", 1'b1, 1'b0, 4'b1111, {8'd3, 8'd2, 8'd1, 8'd0}, '0, 0, 1'b0);
        check("t1_rdata", lane_read_data, {64'd48, 64'd32, 64'd16, 64'd0});
        check("t1_done", {252'd0, lane_done}, {252'd0, 4'b1111});
        check("t1_ntxn", n_txn, 4);

        // 2: sparse store with ack three cycles late
        n_txn = 0; n_rd = 0; n_wr = 0;
        run_op("t2", 1'b0, 1'b1, 4'b1010, {8'd7, 8'd0, 8'd5, 8'd0},
               {64'hBB, 64'h0, 64'hAA, 64'h0}, 3, 1'b0);
        check("t2_done", {252'd0, lane_done}, {252'd0, 4'b1010});
        check("t2_no_read", n_rd, 0);
        check("t2_ntxn", n_txn, 2);
        check("t2_rdata_hold", lane_read_data, {64'd48, 64'd32, 64'd16, 64'd0});

        // 3: empty mask
        n_txn = 0;
        run_op("t3", 1'b1, 1'b0, 4'b0000, {8'd9, 8'd9, 8'd9, 8'd9}, '0, 0, 1'b0);
        check("t3_ntxn", n_txn, 0);
        check("t3_done", {252'd0, lane_done}, 256'd0);

        // 4: reset while lane 2 is waiting
        ack_delay  = 3;
        simd_state = 3'b011;
        mem_read   = 1'b1;
        mem_write  = 1'b0;
        lane_mask  = 4'b1111;
        lane_addr  = {8'd23, 8'd22, 8'd21, 8'd20};
        for (int i = 0; i < 4; i++) begin
            txn_t t;
            t.is_read = 1'b1;
            t.addr    = 8'(20 + i);
            t.data    = '0;
            sb.push_back(t);
        end
        tick();
        simd_state = 3'b000;
        for (int n = 0; n < 60 && !(mem_read_valid && mem_read_addr == 8'd22); n++) tick();
        check("t4_reached_lane2", {255'd0, mem_read_valid && mem_read_addr == 8'd22}, 256'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t4_valids", {254'd0, mem_read_valid, mem_write_valid}, 256'd0);
        check("t4_state", {254'd0, lsu_state}, 256'd0);
        check("t4_done", {252'd0, lane_done}, 256'd0);
        check("t4_rdata", lane_read_data, 256'd0);
        #2 rst_n = 1'b1;
        sb.delete();
        tick();

        // 5: enable low while ack is held high
        man_mode   = 1'b1;
        man_rack   = 1'b0;
        simd_state = 3'b011;
        mem_read   = 1'b1;
        lane_mask  = 4'b0001;
        lane_addr  = {8'd0, 8'd0, 8'd0, 8'd9};
        tick();
        simd_state = 3'b000;
        tick();
        check("t5_wait", {254'd0, lsu_state}, {254'd0, 2'b10});
        check("t5_addr", {248'd0, mem_read_addr}, {248'd0, 8'd9});
        enable    = 1'b0;
        man_rack  = 1'b1;
        man_rdata = 64'h55;
        for (int n = 0; n < 5; n++) begin
            tick();
            check("t5_hold_state", {254'd0, lsu_state}, {254'd0, 2'b10});
            check("t5_hold_valid", {255'd0, mem_read_valid}, 256'd1);
            check("t5_hold_done", {252'd0, lane_done}, 256'd0);
        end
        enable = 1'b1;
        tick();
        check("t5_state_done", {254'd0, lsu_state}, {254'd0, 2'b11});
        check("t5_lane_done", {252'd0, lane_done}, 256'd1);
        check("t5_rdata", lane_read_data, {192'd0, 64'h55});
        man_rack   = 1'b0;
        simd_state = 3'b110;
        tick();
        check("t5_idle", {254'd0, lsu_state}, 256'd0);
        simd_state = 3'b000;
        man_mode   = 1'b0;
        tick();

        // 6: read wins over write; inputs scrambled after capture
        n_txn = 0; n_wr = 0;
        run_op("t6", 1'b1, 1'b1, 4'b1111, {8'd13, 8'd12, 8'd11, 8'd10}, '0, 1, 1'b1);
        check("t6_rdata", lane_read_data, {64'd208, 64'd192, 64'd176, 64'd160});
        check("t6_no_write", n_wr, 0);
        check("t6_ntxn", n_txn, 4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
